// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit processor; drives the ALU and owns PC, R0-R7 and {C,N,V,Z}.
// Latency 5 cycles (ALU/branch) or 6 (LD/ST) with zero-wait acks; each ack wait cycle holds the request and adds one cycle.
module control_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter bit          R0_ZERO  = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic [15:0] imem_rdata_i,
    input  logic        imem_ack_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [15:0] dmem_addr_o,
    output logic [15:0] dmem_wdata_o,
    input  logic [15:0] dmem_rdata_i,
    input  logic        dmem_ack_i,
    output logic [3:0]  alu_func_o,
    output logic [15:0] alu_op0_o,
    output logic [15:0] alu_op1_o,
    output logic        alu_flag_en_o,
    output logic [3:0]  alu_flag_in_o,
    input  logic [15:0] alu_q_i,
    input  logic [3:0]  alu_flag_out_i,
    output logic [15:0] pc_out_o,
    output logic [3:0]  flags_out_o,
    output logic        retire_o
);

    localparam logic [3:0] OP_JMP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_MOV = 4'hA;
    localparam logic [3:0] OP_BEQ = 4'hB;
    localparam logic [3:0] OP_BNE = 4'hC;
    localparam logic [3:0] OP_BLT = 4'hD;
    localparam logic [3:0] OP_BGT = 4'hE;
    localparam logic [3:0] OP_CMP = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] ir_q;
    logic [3:0]  flags_q;
    logic [15:0] rf_q [8];
    logic        imem_req_q;
    logic        dmem_req_q;
    logic        dmem_we_q;
    logic [15:0] dmem_addr_q;
    logic [15:0] dmem_wdata_q;
    logic [3:0]  alu_func_q;
    logic [15:0] alu_op0_q;
    logic [15:0] alu_op1_q;
    logic        alu_flag_en_q;
    logic [3:0]  alu_flag_in_q;
    logic        retire_q;

    logic [3:0]  op_d;
    logic [2:0]  rd_d;
    logic [2:0]  rs_d;
    logic [2:0]  rt_d;
    logic [15:0] rs_val_d;
    logic [15:0] rt_val_d;
    logic [15:0] rd_val_d;
    logic [15:0] op0_d;
    logic [15:0] op1_d;
    logic        flag_en_d;
    logic [3:0]  flag_in_d;
    logic        taken_d;
    logic [15:0] br_pc_d;
    logic        rd_wr_ok_d;

    assign op_d       = ir_q[15:12];
    assign rd_d       = ir_q[11:9];
    assign rs_d       = ir_q[8:6];
    assign rt_d       = ir_q[2:0];
    assign rs_val_d   = (R0_ZERO && rs_d == 3'd0) ? 16'h0000 : rf_q[rs_d];
    assign rt_val_d   = (R0_ZERO && rt_d == 3'd0) ? 16'h0000 : rf_q[rt_d];
    assign rd_val_d   = (R0_ZERO && rd_d == 3'd0) ? 16'h0000 : rf_q[rd_d];
    assign rd_wr_ok_d = !(R0_ZERO && rd_d == 3'd0);
    assign op0_d      = (op_d == OP_MOV) ? 16'h0000 : rs_val_d;
    assign op1_d      = ir_q[5] ? {11'h000, ir_q[4:0]} : rt_val_d;
    assign flag_en_d  = (op_d >= 4'h1 && op_d <= 4'h7) || (op_d == OP_CMP);
    // Only the carry-chain ops see the stored carry; everything else gets C=0.
    assign flag_in_d  = (op_d == OP_ADD || op_d == OP_SUB || op_d == OP_CMP) ?
                        flags_q : {1'b0, flags_q[2:0]};
    // pc_q already points past the branch when this is used in EXEC.
    assign br_pc_d    = pc_q + {{4{ir_q[11]}}, ir_q[11:0]};

    always_comb begin
        taken_d = 1'b0;
        case (op_d)
            OP_BEQ:  taken_d = flags_q[0];
            OP_BNE:  taken_d = !flags_q[0];
            OP_BLT:  taken_d = flags_q[2] && !flags_q[0];
            OP_BGT:  taken_d = !flags_q[2] && !flags_q[0];
            default: taken_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            flags_q       <= '0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
            imem_req_q    <= 1'b0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= '0;
            dmem_wdata_q  <= '0;
            alu_func_q    <= '0;
            alu_op0_q     <= '0;
            alu_op1_q     <= '0;
            alu_flag_en_q <= 1'b0;
            alu_flag_in_q <= '0;
            retire_q      <= 1'b0;
        end else begin
            retire_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    // First FETCH cycle raises the request; ack is only honoured once it is up.
                    if (!imem_req_q) begin
                        imem_req_q <= 1'b1;
                    end else if (imem_ack_i) begin
                        ir_q       <= imem_rdata_i;
                        pc_q       <= pc_q + 16'd1;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_func_q    <= op_d;
                    alu_op0_q     <= op0_d;
                    alu_op1_q     <= op1_d;
                    alu_flag_en_q <= flag_en_d;
                    alu_flag_in_q <= flag_in_d;
                    state_q       <= S_EXEC;
                end
                S_EXEC: begin
                    state_q  <= S_WB;
                    retire_q <= 1'b1;
                    case (op_d)
                        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                            if (rd_wr_ok_d) rf_q[rd_d] <= alu_q_i;
                            flags_q <= alu_flag_out_i;
                        end
                        OP_CMP: flags_q <= alu_flag_out_i;
                        OP_MOV: if (rd_wr_ok_d) rf_q[rd_d] <= alu_q_i;
                        OP_JMP: pc_q <= alu_q_i;
                        OP_BEQ, OP_BNE, OP_BLT, OP_BGT: if (taken_d) pc_q <= br_pc_d;
                        default: begin
                            // LD (1000) / ST (1001): address comes from the ALU
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= (op_d == OP_ST);
                            dmem_addr_q  <= alu_q_i;
                            dmem_wdata_q <= (op_d == OP_ST) ? rd_val_d : dmem_wdata_q;
                            state_q      <= S_MEM;
                            retire_q     <= 1'b0;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack_i) begin
                        dmem_req_q <= 1'b0;
                        if (!dmem_we_q && rd_wr_ok_d) rf_q[rd_d] <= dmem_rdata_i;
                        state_q    <= S_WB;
                        retire_q   <= 1'b1;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign imem_req_o    = imem_req_q;
    assign imem_addr_o   = pc_q;
    assign dmem_req_o    = dmem_req_q;
    assign dmem_we_o     = dmem_we_q;
    assign dmem_addr_o   = dmem_addr_q;
    assign dmem_wdata_o  = dmem_wdata_q;
    assign alu_func_o    = alu_func_q;
    assign alu_op0_o     = alu_op0_q;
    assign alu_op1_o     = alu_op1_q;
    assign alu_flag_en_o = alu_flag_en_q;
    assign alu_flag_in_o = alu_flag_in_q;
    assign pc_out_o      = pc_q;
    assign flags_out_o   = flags_q;
    assign retire_o      = retire_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: acts as instruction memory, data memory and ALU, and tracks an ISA-level model.
module tb_control_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic [15:0] imem_rdata_i;
    logic        imem_ack_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [15:0] dmem_addr_o;
    logic [15:0] dmem_wdata_o;
    logic [15:0] dmem_rdata_i;
    logic        dmem_ack_i;
    logic [3:0]  alu_func_o;
    logic [15:0] alu_op0_o;
    logic [15:0] alu_op1_o;
    logic        alu_flag_en_o;
    logic [3:0]  alu_flag_in_o;
    logic [15:0] alu_q_i;
    logic [3:0]  alu_flag_out_i;
    logic [15:0] pc_out_o;
    logic [3:0]  flags_out_o;
    logic        retire_o;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_r [8];
    logic [15:0] m_pc;
    logic [3:0]  m_flags;
    logic [15:0] dm [256];

    control_sequencer #(.RESET_PC(16'h0000), .R0_ZERO(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_rdata_i(imem_rdata_i), .imem_ack_i(imem_ack_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
        .alu_func_o(alu_func_o), .alu_op0_o(alu_op0_o), .alu_op1_o(alu_op1_o),
        .alu_flag_en_o(alu_flag_en_o), .alu_flag_in_o(alu_flag_in_o),
        .alu_q_i(alu_q_i), .alu_flag_out_i(alu_flag_out_i),
        .pc_out_o(pc_out_o), .flags_out_o(flags_out_o), .retire_o(retire_o)
    );

    always #5 clk_i = ~clk_i;

    // External ALU: returns {C,N,V,Z,Q}
    function automatic logic [19:0] alu_fn(input logic [3:0] f, input logic [15:0] a,
                                           input logic [15:0] b, input logic [3:0] fin);
        logic [16:0] t;
        logic        v;
        v = 1'b0;
        case (f)
            4'h1: begin
                t = {1'b0, a} + {1'b0, b} + {16'h0000, fin[3]};
                v = (a[15] == b[15]) && (t[15] != a[15]);
            end
            4'h2, 4'hF: begin
                t = {1'b0, a} - {1'b0, b} - {16'h0000, fin[3]};
                v = (a[15] != b[15]) && (t[15] != a[15]);
            end
            4'h3:    t = {1'b0, a & b};
            4'h4:    t = {1'b0, a | b};
            4'h5:    t = {1'b0, a ^ b};
            4'h6:    t = {1'b0, a << b[3:0]};
            4'h7:    t = {1'b0, a >> b[3:0]};
            default: t = {1'b0, a} + {1'b0, b};
        endcase
        return {t[16], t[15], v, (t[15:0] == 16'h0000), t[15:0]};
    endfunction

    always_comb begin
        {alu_flag_out_i, alu_q_i} = alu_fn(alu_func_o, alu_op0_o, alu_op1_o, alu_flag_in_o);
    end

    function automatic logic [15:0] ei(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [4:0] imm);
        return {op, rd, rs, 1'b1, imm};
    endfunction

    function automatic logic [15:0] er(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, 3'b000, rt};
    endfunction

    function automatic logic [15:0] rr(input logic [2:0] idx);
        return (idx == 3'd0) ? 16'h0000 : m_r[idx];
    endfunction

    task automatic wr(input logic [2:0] idx, input logic [15:0] val);
        if (idx != 3'd0) m_r[idx] = val;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
        m_pc    = 16'h0000;
        m_flags = 4'h0;
    endtask

    // Starts and ends on the negedge of the first FETCH cycle.
    task automatic run_instr(input logic [15:0] ins, input int iw, input int dw, input bit rst_mem);
        logic [3:0]  op;
        logic [15:0] e_op0, e_op1, e_q, st_dat;
        logic [3:0]  e_fin, e_fo;
        logic        e_fen, taken, is_mem;
        logic [19:0] res;
        op = ins[15:12];
        chk("f0_req", imem_req_o, 1'b0);
        chk("f0_retire", retire_o, 1'b0);
        step();
        dmem_ack_i = 1'b0;
        for (int k = 0; k < iw; k++) begin
            chk("fetch_wait_req", imem_req_o, 1'b1);
            chk("fetch_wait_addr", imem_addr_o, m_pc);
            step();
        end
        chk("fetch_req", imem_req_o, 1'b1);
        chk("fetch_addr", imem_addr_o, m_pc);
        imem_ack_i   = 1'b1;
        imem_rdata_i = ins;
        step();
        imem_ack_i   = 1'b0;
        imem_rdata_i = 16'($urandom);
        chk("dec_req_drop", imem_req_o, 1'b0);
        e_op0  = (op == 4'hA) ? 16'h0000 : rr(ins[8:6]);
        e_op1  = ins[5] ? {11'h000, ins[4:0]} : rr(ins[2:0]);
        e_fen  = (op inside {[4'h1:4'h7]}) || op == 4'hF;
        e_fin  = (op == 4'h1 || op == 4'h2 || op == 4'hF) ? m_flags : {1'b0, m_flags[2:0]};
        res    = alu_fn(op, e_op0, e_op1, e_fin);
        e_q    = res[15:0];
        e_fo   = res[19:16];
        st_dat = rr(ins[11:9]);
        m_pc   = m_pc + 16'd1;
        chk("dec_pc", pc_out_o, m_pc);
        step();
        chk("alu_func", alu_func_o, op);
        chk("alu_op0", alu_op0_o, e_op0);
        chk("alu_op1", alu_op1_o, e_op1);
        chk("alu_flag_en", alu_flag_en_o, e_fen);
        chk("alu_flag_in", alu_flag_in_o, e_fin);
        is_mem = (op == 4'h8 || op == 4'h9);
        case (op)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin wr(ins[11:9], e_q); m_flags = e_fo; end
            4'hF: m_flags = e_fo;
            4'hA: wr(ins[11:9], e_q);
            4'h0: m_pc = e_q;
            4'hB, 4'hC, 4'hD, 4'hE: begin
                case (op)
                    4'hB:    taken = m_flags[0];
                    4'hC:    taken = !m_flags[0];
                    4'hD:    taken = m_flags[2] && !m_flags[0];
                    default: taken = !m_flags[2] && !m_flags[0];
                endcase
                if (taken) m_pc = m_pc + {{4{ins[11]}}, ins[11:0]};
            end
            default: ;
        endcase
        step();
        if (is_mem) begin
            for (int k = 0; k <= dw; k++) begin
                chk("mem_req", dmem_req_o, 1'b1);
                chk("mem_we", dmem_we_o, (op == 4'h9));
                chk("mem_addr", dmem_addr_o, e_q);
                if (op == 4'h9) chk("mem_wdata", dmem_wdata_o, st_dat);
                if (rst_mem) begin
                    rst_i        = 1'b1;
                    dmem_ack_i   = 1'b1;
                    dmem_rdata_i = 16'hDEAD;
                    step();
                    chk("rst_dmem_req", dmem_req_o, 1'b0);
                    chk("rst_pc", pc_out_o, 16'h0000);
                    chk("rst_imem_addr", imem_addr_o, 16'h0000);
                    chk("rst_imem_req", imem_req_o, 1'b0);
                    chk("rst_flags", flags_out_o, 4'h0);
                    chk("rst_alu_op0", alu_op0_o, 16'h0000);
                    chk("rst_retire", retire_o, 1'b0);
                    step();
                    rst_i = 1'b0;
                    model_reset();
                    return;
                end
                if (k < dw) step();
            end
            dmem_ack_i   = 1'b1;
            dmem_rdata_i = dm[e_q[7:0]];
            if (op == 4'h8) wr(ins[11:9], dm[e_q[7:0]]);
            else dm[e_q[7:0]] = st_dat;
            step();
            dmem_ack_i   = 1'b0;
            dmem_rdata_i = 16'($urandom);
        end
        chk("wb_retire", retire_o, 1'b1);
        chk("wb_dmem_req", dmem_req_o, 1'b0);
        chk("wb_pc", pc_out_o, m_pc);
        chk("wb_flags", flags_out_o, m_flags);
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) dm[i] = 16'h0000;
        model_reset();
        rst_i        = 1'b1;
        imem_ack_i   = 1'b1;
        imem_rdata_i = 16'h1FFF;
        dmem_ack_i   = 1'b1;
        dmem_rdata_i = 16'h0000;
        step();
        step();
        chk("reset_pc", pc_out_o, 16'h0000);
        chk("reset_imem_req", imem_req_o, 1'b0);
        chk("reset_dmem_req", dmem_req_o, 1'b0);
        chk("reset_retire", retire_o, 1'b0);
        chk("reset_alu_en", alu_flag_en_o, 1'b0);
        rst_i      = 1'b0;
        imem_ack_i = 1'b0;

        // MOV/MOV/ADD
        run_instr(ei(4'hA, 3'd1, 3'd0, 5'd5), 0, 0, 0);
        run_instr(ei(4'hA, 3'd2, 3'd0, 5'd3), 1, 0, 0);
        run_instr(er(4'h1, 3'd3, 3'd1, 3'd2), 0, 0, 0);
        chk("add_flags", flags_out_o, 4'b0000);
        // R1=8000, SUB with C=0, then CMP
        run_instr(ei(4'hA, 3'd1, 3'd0, 5'd1), 0, 0, 0);
        run_instr(ei(4'h6, 3'd1, 3'd1, 5'd15), 0, 0, 0);
        run_instr(ei(4'h1, 3'd6, 3'd0, 5'd1), 2, 0, 0);
        run_instr(ei(4'h2, 3'd1, 3'd1, 5'd0), 0, 0, 0);
        chk("sub_flags", flags_out_o, 4'b0100);
        run_instr(er(4'hF, 3'd0, 3'd1, 3'd1), 0, 0, 0);
        chk("cmp_flags", flags_out_o, 4'b0001);
        // JMP to 0010, BEQ -2 taken then not taken
        run_instr(ei(4'h0, 3'd0, 3'd0, 5'd16), 0, 0, 0);
        run_instr({4'hB, 12'hFFE}, 0, 0, 0);
        chk("beq_taken_pc", pc_out_o, 16'h000F);
        run_instr(ei(4'h1, 3'd6, 3'd0, 5'd1), 0, 0, 0);
        run_instr({4'hB, 12'hFFE}, 0, 0, 0);
        chk("beq_not_taken_pc", pc_out_o, 16'h0011);
        // R1=0100, R2=ABCD, ST with 3 wait cycles, LD back
        run_instr(ei(4'hA, 3'd1, 3'd0, 5'd1), 0, 0, 0);
        run_instr(ei(4'h6, 3'd1, 3'd1, 5'd8), 0, 0, 0);
        run_instr(ei(4'hA, 3'd2, 3'd0, 5'h0A), 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            run_instr(ei(4'h6, 3'd2, 3'd2, 5'd4), 0, 0, 0);
            run_instr(ei(4'h4, 3'd2, 3'd2, 5'(5'h0B + n)), 0, 0, 0);
        end
        run_instr(ei(4'h9, 3'd2, 3'd1, 5'd4), 0, 3, 0);
        run_instr(ei(4'h8, 3'd4, 3'd1, 5'd4), 1, 2, 0);
        run_instr(ei(4'h1, 3'd5, 3'd4, 5'd0), 0, 0, 0);
        // Reset during a data request, then R0 writes discarded
        run_instr(ei(4'h9, 3'd2, 3'd1, 5'd4), 0, 2, 1);
        run_instr(ei(4'h1, 3'd3, 3'd1, 5'd0), 0, 0, 0);
        run_instr(ei(4'hA, 3'd0, 3'd0, 5'd7), 0, 0, 0);
        run_instr(er(4'h1, 3'd1, 3'd0, 3'd0), 0, 0, 0);
        // Randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            run_instr(16'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
